// File: rtl/indirect_csr_target.sv
`default_nettype none
// ============================================================================
// Module   : indirect_csr_target
// Brief    : 64-bit CSR target with DFH, scratchpads and a STAT counter
//            register. Optional macro INDIRECT_CSR_BYTE_EN enables byte-masked
//            scratch writes.
// Revision : 1.0
// ============================================================================
module indirect_csr_target #(
    parameter int          NUM_SCRATCH = 1,
    parameter logic [63:0] DFH_VALUE   = 64'h3_00000_001000_0020,
    parameter int          ADDR_W      = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [63:0]       req_wdata,
    input  logic [7:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [63:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int                WORD_W   = ADDR_W - 3;
    localparam logic [WORD_W-1:0] STAT_IDX = WORD_W'(NUM_SCRATCH + 1);
    localparam logic [15:0]       CNT_MAX  = 16'hFFFF;

    logic [63:0] scratch_q [NUM_SCRATCH];
    logic [63:0] scratch_d [NUM_SCRATCH];
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic        sticky_q, sticky_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [63:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    logic              w_accept;
    logic              w_misaligned;
    logic              w_is_dfh;
    logic              w_is_scr;
    logic              w_is_stat;
    logic              w_err;
    logic              w_clr_be;
    logic              w_stat_clear;
    logic [WORD_W-1:0] w_word;
    logic [63:0]       w_wmask;
    logic [63:0]       w_rdval;

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign w_accept  = req_valid && req_ready;

    assign w_word       = req_addr[ADDR_W-1:3];
    assign w_misaligned = |req_addr[2:0];
    assign w_is_dfh     = (w_word == '0);
    assign w_is_scr     = (w_word != '0) && (w_word <= WORD_W'(NUM_SCRATCH));
    assign w_is_stat    = (w_word == STAT_IDX);
    assign w_err        = w_misaligned || !(w_is_dfh || w_is_scr || w_is_stat)
                          || (w_is_dfh && req_write);

`ifdef INDIRECT_CSR_BYTE_EN
    for (genvar b = 0; b < 8; b++) begin : g_be_mask
        assign w_wmask[8*b +: 8] = {8{req_be[b]}};
    end
    assign w_clr_be = req_be[0];
`else
    logic w_unused_be;
    assign w_unused_be = ^req_be;
    assign w_wmask     = '1;
    assign w_clr_be    = 1'b1;
`endif

    // The clear bit is only honoured on a well-formed STAT write.
    assign w_stat_clear = w_accept && req_write && w_is_stat && !w_misaligned
                          && req_wdata[0] && w_clr_be;

    always_comb begin
        w_rdval = '0;
        if (w_is_dfh) begin
            w_rdval = DFH_VALUE;
        end else if (w_is_stat) begin
            w_rdval = {sticky_q, 15'd0, err_cnt_q, rd_cnt_q, wr_cnt_q};
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_word == WORD_W'(i + 1)) begin
                    w_rdval = scratch_q[i];
                end
            end
        end
    end

    always_comb begin
        scratch_d   = scratch_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        err_cnt_d   = err_cnt_q;
        sticky_d    = sticky_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (w_accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = w_err;
            rsp_rdata_d = (w_err || req_write) ? 64'd0 : w_rdval;

            if (req_write) begin
                wr_cnt_d = (wr_cnt_q == CNT_MAX) ? wr_cnt_q : wr_cnt_q + 16'd1;
            end else begin
                rd_cnt_d = (rd_cnt_q == CNT_MAX) ? rd_cnt_q : rd_cnt_q + 16'd1;
            end

            if (w_err) begin
                err_cnt_d = (err_cnt_q == CNT_MAX) ? err_cnt_q : err_cnt_q + 16'd1;
                sticky_d  = 1'b1;
            end

            if (w_stat_clear) begin
                wr_cnt_d  = '0;
                rd_cnt_d  = '0;
                err_cnt_d = '0;
                sticky_d  = 1'b0;
            end

            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (req_write && !w_err && (w_word == WORD_W'(i + 1))) begin
                    scratch_d[i] = (scratch_q[i] & ~w_wmask) | (req_wdata & w_wmask);
                end
            end
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            err_cnt_q   <= '0;
            sticky_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            scratch_q   <= scratch_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            err_cnt_q   <= err_cnt_d;
            sticky_q    <= sticky_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_indirect_csr_target.sv
`default_nettype none
// ============================================================================
// Module   : tb_indirect_csr_target
// Brief    : Scoreboard bench for indirect_csr_target against a register model.
// Revision : 1.0
// ============================================================================
module tb_indirect_csr_target;
    localparam int          NS  = 1;
    localparam logic [63:0] DFH = 64'h3_00000_001000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [11:0] req_addr  = '0;
    logic [63:0] req_wdata = '0;
    logic [7:0]  req_be    = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    always #5 clk = ~clk;

    indirect_csr_target dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          acc_cyc = -10;
    bit          rand_rdy  = 1'b0;
    bit          rdy_force = 1'b1;
    bit          held      = 1'b0;
    logic [63:0] held_d;
    logic        held_e;

    // Register model: plain integers for counters, saturated by comparison.
    logic [63:0] m_scr [NS];
    int          m_wr, m_rd, m_er;
    bit          m_sticky;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) m_scr[i] = '0;
        m_wr = 0; m_rd = 0; m_er = 0; m_sticky = 1'b0;
    endfunction

    function automatic exp_t model_access(bit wr, logic [11:0] a, logic [63:0] wd, logic [7:0] be);
        exp_t        e;
        int          w;
        bit          mis, dfh, scr, st, clr_ok;
        logic [63:0] mask;
        w    = int'(a >> 3);
        mis  = (a[2:0] != 3'd0);
        dfh  = (w == 0);
        scr  = (w >= 1) && (w <= NS);
        st   = (w == NS + 1);
`ifdef INDIRECT_CSR_BYTE_EN
        for (int b = 0; b < 8; b++) mask[8*b +: 8] = {8{be[b]}};
        clr_ok = be[0];
`else
        mask   = '1;
        clr_ok = 1'b1;
`endif
        e.err   = mis || !(dfh || scr || st) || (dfh && wr);
        e.rdata = '0;
        if (!e.err && !wr) begin
            if (dfh)      e.rdata = DFH;
            else if (scr) e.rdata = m_scr[w-1];
            else          e.rdata = {m_sticky, 15'd0, 16'(m_er), 16'(m_rd), 16'(m_wr)};
        end
        if (wr) begin
            if (m_wr < 65535) m_wr++;
        end else begin
            if (m_rd < 65535) m_rd++;
        end
        if (e.err) begin
            if (m_er < 65535) m_er++;
            m_sticky = 1'b1;
        end
        if (!e.err && wr && scr) m_scr[w-1] = (m_scr[w-1] & ~mask) | (wd & mask);
        if (!e.err && wr && st && wd[0] && clr_ok) begin
            m_wr = 0; m_rd = 0; m_er = 0; m_sticky = 1'b0;
        end
        return e;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) rsp_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : rdy_force;

    // Response check: pops the scoreboard on every handshake, checks holds.
    always @(negedge clk) begin : mon
        exp_t e;
        #2;
        if (rst) begin
            held = 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", 64'(rsp_valid), 64'd1);
                chk("hold_rdata", rsp_rdata, held_d);
                chk("hold_err", 64'(rsp_err), 64'(held_e));
            end
            held = 1'b0;
            if (rsp_valid && rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got rdata %h err %0b, expected no response", rsp_rdata, rsp_err);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_rdata", rsp_rdata, e.rdata);
                    chk("rsp_err", 64'(rsp_err), 64'(e.err));
                end
            end else if (rsp_valid) begin
                held   = 1'b1;
                held_d = rsp_rdata;
                held_e = rsp_err;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && acc_cyc == cyc - 1) chk("latency_valid", 64'(rsp_valid), 64'd1);
    end

    task automatic idle_garbage();
        logic [63:0] r;
        r         = {$urandom, $urandom};
        req_valid = 1'b0;
        req_write = r[0];
        req_addr  = r[11:0];
        req_wdata = {$urandom, $urandom};
        req_be    = r[19:12];
    endtask

    task automatic do_req(bit wr, logic [11:0] a, logic [63:0] wd, logic [7:0] be);
        int n;
        n = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        req_be    = be;
        #1;
        while (!req_ready) begin
            n++;
            if (n > 200) begin
                n_cmp++;
                n_fail++;
                $display("FAIL accept_timeout: got req_ready 0 for %0d cycles, expected acceptance", n);
                idle_garbage();
                return;
            end
            @(negedge clk);
            #1;
        end
        sb_q.push_back(model_access(wr, a, wd, be));
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        idle_garbage();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
    endtask

    task automatic reset_dut();
        rdy_force = 1'b1;
        drain();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb_q.delete();
        acc_cyc = -10;
    endtask

    initial begin
        logic [63:0] r;
        logic [11:0] a;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_rdata", rsp_rdata, 64'd0);
        chk("rst_rsp_err", 64'(rsp_err), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 64'(req_ready), 64'd1);

        do_req(1'b0, 12'h000, '0, 8'hFF);

        reset_dut();
        do_req(1'b1, 12'h008, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        do_req(1'b0, 12'h008, '0, 8'hFF);
        do_req(1'b0, 12'h010, '0, 8'hFF);

        reset_dut();
        do_req(1'b0, 12'hFF8, '0, 8'hFF);
        do_req(1'b1, 12'h004, 64'h1234, 8'hFF);
        do_req(1'b0, 12'h010, '0, 8'hFF);

        // Backpressure: second request must stall while the first response is held.
        drain();
        rdy_force = 1'b0;
        do_req(1'b0, 12'h008, '0, 8'hFF);
        fork
            do_req(1'b0, 12'h000, '0, 8'hFF);
            begin
                repeat (5) begin
                    @(negedge clk);
                    #2;
                    chk("bp_req_ready", 64'(req_ready), 64'd0);
                end
                rdy_force = 1'b1;
            end
        join

        for (int i = 0; i < 4; i++) do_req(1'b0, 12'(8 * (i % (NS + 2))), '0, 8'hFF);

        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
            r = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0:       a = 12'h000;
                1:       a = 12'(8 * $urandom_range(1, NS));
                2:       a = 12'(8 * (NS + 1));
                3:       a = r[11:0] & 12'hFF8;
                default: a = r[11:0];
            endcase
            do_req(r[63], a, {$urandom, $urandom}, r[47:40]);
        end
        rand_rdy  = 1'b0;
        rdy_force = 1'b1;

        reset_dut();
        do_req(1'b1, 12'h008, '1, 8'h0F);
        do_req(1'b0, 12'h008, '0, 8'hFF);

        reset_dut();
        for (int i = 0; i < 70000; i++) do_req(1'b1, 12'h008, {$urandom, $urandom}, 8'hFF);
        do_req(1'b0, 12'(8 * (NS + 1)), '0, 8'hFF);
        do_req(1'b1, 12'(8 * (NS + 1)), 64'd1, 8'hFF);
        do_req(1'b0, 12'(8 * (NS + 1)), '0, 8'hFF);
        do_req(1'b0, 12'(8 * (NS + 1)), '0, 8'hFF);

        // Asynchronous reset with a response pending; requests during reset are ignored.
        drain();
        rdy_force = 1'b0;
        do_req(1'b0, 12'h000, '0, 8'hFF);
        #2;
        chk("pre_rst_valid", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(rsp_valid), 64'd0);
        chk("async_rst_rdata", rsp_rdata, 64'd0);
        chk("async_rst_err", 64'(rsp_err), 64'd0);
        chk("async_rst_ready", 64'(req_ready), 64'd1);
        sb_q.delete();
        acc_cyc   = -10;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h008;
        req_wdata = '1;
        req_be    = 8'hFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        rdy_force = 1'b1;
        model_reset();
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        do_req(1'b0, 12'h008, '0, 8'hFF);
        do_req(1'b0, 12'(8 * (NS + 1)), '0, 8'hFF);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/indirect_csr_target.md
INDIRECT_CSR_TARGET -- requirements
Module: indirect_csr_target

Interface
REQ-001 SHALL have parameter NUM_SCRATCH, default 1, number of RW scratchpad registers (legal 1..8).
REQ-002 SHALL have parameter DFH_VALUE, default 64'h3_00000_001000_0020, read-only DFH contents.
REQ-003 SHALL have parameter ADDR_W, default 12, byte-address width; data width fixed at 64.
REQ-004 SHALL have port clk  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have ports req_valid in 1, req_ready out 1: request handshake.
REQ-007 SHALL have ports req_write in 1 (1=write), req_addr in ADDR_W (byte address), req_wdata in 64, req_be in 8 (byte enables).
REQ-008 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out 64, rsp_err out 1: response channel.

Function
REQ-009 SHALL use map: 0x000 DFH (RO); 0x008+8*i SCRATCH[i], i<NUM_SCRATCH (RW); STAT at 0x008+8*NUM_SCRATCH; all other offsets up to 2^ADDR_W-8 unmapped.
REQ-010 SHALL accept a request when req_valid and req_ready are both 1; req_ready = !rsp_valid | rsp_ready (combinational).
REQ-011 SHALL assert rsp_valid exactly one cycle after acceptance, for reads and writes, holding rsp_rdata/rsp_err stable until rsp_valid & rsp_ready.
REQ-012 SHALL sustain one request per cycle when rsp_ready is held 1; at most one response outstanding.
REQ-013 SHALL return rsp_rdata = register value before any update by the same access; writes return rsp_rdata = 0.
REQ-014 SHALL treat req_addr[2:0] != 0 as misaligned: no state change except error accounting, rsp_err=1, rsp_rdata=0.
REQ-015 SHALL treat unmapped or DFH-write accesses as errors: ignore write, rsp_rdata=0, rsp_err=1.
REQ-016 SHALL define STAT fields: [15:0] accepted-write count, [31:16] accepted-read count, [47:32] error count, [62:48] 0, [63] sticky error flag.
REQ-017 SHALL saturate each STAT count at 16'hFFFF (no wrap).
REQ-018 SHALL count every accepted request in exactly one of write/read count; erroring accesses also increment error count and set bit 63.
REQ-019 SHALL, on a mapped write to STAT with req_wdata[0]=1 (and req_be[0]=1 when byte enables active), clear all STAT fields; clear wins over the increment from that same write.
REQ-020 SHALL treat a STAT write with wdata[0]=0 as a normal counted write with no other effect.
REQ-021 SHALL ignore req_* inputs when no acceptance occurs.

Reset
REQ-022 SHALL, on rst assertion (asynchronous), force rsp_valid=0, rsp_rdata=0, rsp_err=0, all SCRATCH=0, all STAT fields=0.
REQ-023 SHALL drop any in-flight response on reset mid-operation; no response emitted for a request accepted in the cycle reset asserts.
REQ-024 SHALL drive req_ready=1 while in reset and first cycle after deassertion, but accept nothing while rst=1.

Configuration
REQ-025 SHALL, with INDIRECT_CSR_BYTE_EN defined, update only SCRATCH bytes whose req_be bit is 1; req_be=0 write is counted, changes nothing, rsp_err=0.
REQ-026 SHALL, without INDIRECT_CSR_BYTE_EN, ignore req_be and write all 64 bits on every scratch write.

Verification
REQ-027 SHALL cover: reset, read 0x000 -> rsp_valid next cycle, rdata=64'h3_00000_001000_0020, err=0.
REQ-028 SHALL cover: write 0x008 data 64'hDEADBEEF_CAFEF00D be=8'hFF, read 0x008 -> same data; STAT read at 0x010 -> 64'h0000_0000_0001_0001 (read of STAT counted after returning: value seen = writes 1, reads 1).
REQ-029 SHALL cover: read 0xFF8 and write 0x004 -> both rsp_err=1, rdata=0; STAT bits [47:32]=2, bit 63=1.
REQ-030 SHALL cover: rsp_ready held 0 for 5 cycles with req_valid=1 -> req_ready=0, response stable, single response on release; back-to-back 4 reads with rsp_ready=1 -> 4 responses on consecutive cycles.
REQ-031 SHALL cover: 70000 writes to SCRATCH -> STAT[15:0]=16'hFFFF; write STAT data=1 -> STAT reads 0 except subsequent read count 1 reflected on next read.
REQ-032 SHALL cover: with INDIRECT_CSR_BYTE_EN, SCRATCH=0, write all-ones be=8'h0F -> reads 64'h0000_0000_FFFF_FFFF; rst asserted with rsp_valid=1 -> rsp_valid=0 immediately.
